risc_v_alu_arbiter: RTL and testbench
=====================================

Name: risc_v_alu_arbiter

Overview:
Round-robin arbiter and issue controller that shares one risc_v_alu instance between NUM_REQ requesters, for example hart contexts or an execute stage plus a debug port. It accepts one instruction per cycle over valid/ready handshakes and drives the ALU combinationally. The ALU outcome is registered into a single response slot, tagged with the requester id and backpressured by rsp_ready. It also keeps a saturating count of illegal ALU operations.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..8.
IDW, $clog2(NUM_REQ), width of requester id.
CNT_W, 16, width of the illegal-operation counter.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
req_valid  input  NUM_REQ  per-requester request valid.
req_ready  output  NUM_REQ  per-requester accept; at most one bit high per cycle.
req_instr  input  NUM_REQ x instruction_t  per-requester instruction.
req_pc  input  NUM_REQ x 32  per-requester PC, used by AUIPC.
rsp_valid  output  1  response slot holds a result.
rsp_ready  input  1  consumer accepts the response.
rsp_id  output  IDW  requester index of the held result.
rsp_result  output  32  ALU result.
rsp_zero  output  1  ALU zero flag.
rsp_illegal  output  1  instruction was not a legal ALU operation.
illegal_count  output  CNT_W  saturating count of accepted illegal operations.

Behaviour:
- Reset (clk edge with reset=1):
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_illegal=0.
  - illegal_count=0, round-robin pointer rr_ptr=0.
  - Any result in flight is discarded.
- issue_en = !rsp_valid || rsp_ready. This is combinational; the response slot drains and refills in the same cycle.
- Arbitration (combinational):
  - Scan req_valid starting at rr_ptr, increasing index modulo NUM_REQ; the first set bit is the grant g.
  - req_ready[g]=1 only when issue_en=1 and some req_valid is set. Otherwise req_ready is all zero.
  - req_ready never depends on req_ready itself. It may depend on req_valid.
- Requester rule: once req_valid[i] is asserted, req_valid[i], req_instr[i] and req_pc[i] stay stable until req_ready[i]=1.
- Transfer: fires when req_valid[g] && req_ready[g].
  - ALU enable=1, instr=req_instr[g], pc=req_pc[g].
  - When no transfer fires, ALU enable=0. The instr and pc inputs are then don't-care but must be driven (0).
- Registration on a transfer edge:
  - rsp_valid<=1, rsp_id<=g.
  - rsp_result<=alu_result, rsp_zero<=zero_flag.
  - rsp_illegal<=!alu_op_legal(instr).
  - rr_ptr<=(g+1) mod NUM_REQ.
- Latency: exactly one cycle from transfer to rsp_valid. Throughput is one per cycle while rsp_ready=1.
- Drain: rsp_valid && rsp_ready with no new transfer gives rsp_valid<=0. The data registers hold their last values.
- Backpressure: rsp_valid=1 && rsp_ready=0 holds every rsp_* output stable, forces req_ready=0, and leaves rr_ptr unchanged.
- rr_ptr changes only on a transfer. Idle cycles and stalls do not move it.
- illegal_count: increments by 1 on each transfer whose instruction is illegal. It saturates at all-ones with no wrap. A drain in the same cycle does not affect it.
- Illegal detection uses the package decode function, not the 32'hDEADBEEF result value. A legal LUI may produce that value.
- A single requester holding valid continuously is granted every cycle. Fairness applies only between competing requesters.
- Reset asserted while rsp_valid=1 and rsp_ready=0: the response is dropped with no handshake. Requesters must re-present their requests after reset.

Decomposition:
- opcodes package gains:
  - function alu_op_legal(instruction_t), returning 1 for the ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, LUI and AUIPC match patterns.
  - typedef alu_rsp_t {result, zero, illegal}.
- Sub-module: one instance of the existing risc_v_alu.
- Round-robin pick logic is a function inside this module. No separate arbiter module.

Test Plan:
- Single ADD: requester 2 only, instr matching M_ADD, rsp_ready=1. req_ready=4'b0100 in the same cycle. Next cycle rsp_valid=1, rsp_id=2, rsp_result equals the ALU's ADD output, rsp_illegal=0. rr_ptr becomes 3.
- Fairness: req_valid=4'b1111 held for 8 cycles with rsp_ready=1. Grant order is 0,1,2,3,0,1,2,3, with rsp_valid continuously 1 from cycle 1.
- Backpressure: after one accepted request, rsp_ready=0 for 3 cycles with req_valid=4'b0011. req_ready=0 and rsp_* stay constant. Raising rsp_ready gives a drain plus a new grant in the same cycle.
- Illegal: instr=32'h0000_0000 gives rsp_illegal=1, rsp_result=32'hDEADBEEF, illegal_count=1. A LUI with imm=20'hDEADB gives rsp_result=32'hDEADB000 and rsp_illegal=0.
- Saturation: force 2^CNT_W+2 illegal transfers. illegal_count ends at 16'hFFFF.
- Reset mid-stall: rsp_valid=1, rsp_ready=0, then reset=1 for 1 cycle. Next cycle rsp_valid=0, illegal_count=0. With req_valid=4'b1000 afterwards, requester 3 is granted. Then with req_valid=4'b1111, requester 0 is granted first.

Source files
------------

// File: rtl/risc_v_alu_arbiter_pkg.sv
// Shared RV32 ALU decode definitions: instruction type, match patterns,
// operation decode and the registered response record.
package risc_v_alu_arbiter_pkg;

    typedef logic [31:0] instruction_t;

    localparam logic [31:0] MASK_R  = 32'hFE00_707F;
    localparam logic [31:0] MASK_U  = 32'h0000_007F;

    localparam logic [31:0] M_ADD   = 32'h0000_0033;
    localparam logic [31:0] M_SUB   = 32'h4000_0033;
    localparam logic [31:0] M_SLL   = 32'h0000_1033;
    localparam logic [31:0] M_SLT   = 32'h0000_2033;
    localparam logic [31:0] M_SLTU  = 32'h0000_3033;
    localparam logic [31:0] M_XOR   = 32'h0000_4033;
    localparam logic [31:0] M_SRL   = 32'h0000_5033;
    localparam logic [31:0] M_SRA   = 32'h4000_5033;
    localparam logic [31:0] M_OR    = 32'h0000_6033;
    localparam logic [31:0] M_AND   = 32'h0000_7033;
    localparam logic [31:0] M_LUI   = 32'h0000_0037;
    localparam logic [31:0] M_AUIPC = 32'h0000_0017;

    // Marker value the ALU drives for anything it cannot execute.
    localparam logic [31:0] ILLEGAL_RESULT = 32'hDEAD_BEEF;

    typedef enum logic [3:0] {
        OP_ADD,
        OP_SUB,
        OP_SLL,
        OP_SLT,
        OP_SLTU,
        OP_XOR,
        OP_SRL,
        OP_SRA,
        OP_OR,
        OP_AND,
        OP_LUI,
        OP_AUIPC,
        OP_ILLEGAL
    } alu_op_e;

    typedef struct packed {
        logic [31:0] result;
        logic        zero;
        logic        illegal;
    } alu_rsp_t;

    function automatic alu_op_e alu_decode(input instruction_t instr);
        alu_op_e op;
        op = OP_ILLEGAL;
        if      ((instr & MASK_R) == M_ADD)   op = OP_ADD;
        else if ((instr & MASK_R) == M_SUB)   op = OP_SUB;
        else if ((instr & MASK_R) == M_SLL)   op = OP_SLL;
        else if ((instr & MASK_R) == M_SLT)   op = OP_SLT;
        else if ((instr & MASK_R) == M_SLTU)  op = OP_SLTU;
        else if ((instr & MASK_R) == M_XOR)   op = OP_XOR;
        else if ((instr & MASK_R) == M_SRL)   op = OP_SRL;
        else if ((instr & MASK_R) == M_SRA)   op = OP_SRA;
        else if ((instr & MASK_R) == M_OR)    op = OP_OR;
        else if ((instr & MASK_R) == M_AND)   op = OP_AND;
        else if ((instr & MASK_U) == M_LUI)   op = OP_LUI;
        else if ((instr & MASK_U) == M_AUIPC) op = OP_AUIPC;
        return op;
    endfunction

    function automatic logic alu_op_legal(input instruction_t instr);
        return alu_decode(instr) != OP_ILLEGAL;
    endfunction

endpackage

// File: rtl/risc_v_alu.sv
// Combinational RV32 integer ALU. This standalone unit has no register-file
// port: operand values are the rs1/rs2 index fields, zero-extended.
module risc_v_alu
    import risc_v_alu_arbiter_pkg::*;
(
    input  logic         enable,
    input  instruction_t instr,
    input  logic [31:0]  pc,
    output logic [31:0]  result,
    output logic         zero
);

    logic        [31:0] op_a;
    logic        [31:0] op_b;
    logic signed [31:0] op_a_s;
    logic signed [31:0] op_b_s;
    logic        [4:0]  shamt;
    logic        [31:0] imm_u;

    assign op_a   = {27'b0, instr[19:15]};
    assign op_b   = {27'b0, instr[24:20]};
    assign op_a_s = op_a;
    assign op_b_s = op_b;
    assign shamt  = op_b[4:0];
    assign imm_u  = {instr[31:12], 12'b0};

    always_comb begin
        result = '0;
        if (enable) begin
            case (alu_decode(instr))
                OP_ADD:   result = op_a + op_b;
                OP_SUB:   result = op_a - op_b;
                OP_SLL:   result = op_a << shamt;
                OP_SLT:   result = {31'b0, op_a_s < op_b_s};
                OP_SLTU:  result = {31'b0, op_a < op_b};
                OP_XOR:   result = op_a ^ op_b;
                OP_SRL:   result = op_a >> shamt;
                OP_SRA:   result = op_a_s >>> shamt;
                OP_OR:    result = op_a | op_b;
                OP_AND:   result = op_a & op_b;
                OP_LUI:   result = imm_u;
                OP_AUIPC: result = pc + imm_u;
                default:  result = ILLEGAL_RESULT;
            endcase
        end
    end

    assign zero = enable && (result == '0);

endmodule

// File: rtl/risc_v_alu_arbiter.sv
// Round-robin issue controller sharing one risc_v_alu between NUM_REQ
// requesters, with a single backpressured response slot.
module risc_v_alu_arbiter
    import risc_v_alu_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ),
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  instruction_t         req_instr [NUM_REQ],
    input  logic [31:0]          req_pc    [NUM_REQ],
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_result,
    output logic                 rsp_zero,
    output logic                 rsp_illegal,
    output logic [CNT_W-1:0]     illegal_count
);

    // Returns {found, index} of the first valid bit scanning upward from ptr.
    function automatic logic [IDW:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                             input logic [IDW-1:0]     ptr);
        logic [IDW:0]   pick;
        logic [IDW-1:0] idx_v;
        int             idx;
        pick = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx   = (int'(ptr) + k) % NUM_REQ;
            idx_v = idx[IDW-1:0];
            if (valid[idx_v]) pick = {1'b1, idx_v};
        end
        return pick;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + CNT_W'(1);
    endfunction

    logic               vld_p1;
    logic [IDW-1:0]     id_p1;
    alu_rsp_t           rsp_p1;
    logic [IDW-1:0]     rr_ptr;
    logic [CNT_W-1:0]   illegal_cnt;

    logic               issue_en;
    logic [IDW:0]       pick;
    logic               found;
    logic [IDW-1:0]     grant;
    logic               fire;
    logic [IDW-1:0]     next_ptr;

    instruction_t       alu_instr;
    logic [31:0]        alu_pc;
    logic [31:0]        alu_result;
    logic               alu_zero;

    // Stage p0: arbitration and combinational ALU drive
    assign issue_en = !vld_p1 || rsp_ready;
    assign pick     = rr_pick(req_valid, rr_ptr);
    assign found    = pick[IDW];
    assign grant    = pick[IDW-1:0];
    assign fire     = issue_en && found;
    assign next_ptr = (grant == IDW'(NUM_REQ - 1)) ? '0 : grant + IDW'(1);

    always_comb begin
        req_ready = '0;
        alu_instr = '0;
        alu_pc    = '0;
        if (fire) begin
            req_ready[grant] = 1'b1;
            alu_instr        = req_instr[grant];
            alu_pc           = req_pc[grant];
        end
    end

    risc_v_alu u_alu (
        .enable (fire),
        .instr  (alu_instr),
        .pc     (alu_pc),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // Stage p1: response slot, pointer and illegal counter
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1      <= 1'b0;
            id_p1       <= '0;
            rsp_p1      <= '0;
            rr_ptr      <= '0;
            illegal_cnt <= '0;
        end else if (fire) begin
            vld_p1         <= 1'b1;
            id_p1          <= grant;
            rsp_p1.result  <= alu_result;
            rsp_p1.zero    <= alu_zero;
            rsp_p1.illegal <= !alu_op_legal(alu_instr);
            rr_ptr         <= next_ptr;
            if (!alu_op_legal(alu_instr)) illegal_cnt <= sat_inc(illegal_cnt);
        end else if (rsp_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign rsp_valid     = vld_p1;
    assign rsp_id        = id_p1;
    assign rsp_result    = rsp_p1.result;
    assign rsp_zero      = rsp_p1.zero;
    assign rsp_illegal   = rsp_p1.illegal;
    assign illegal_count = illegal_cnt;

endmodule

// File: tb/tb_risc_v_alu_arbiter.sv
// Directed bench for risc_v_alu_arbiter: table of single-issue ALU vectors
// followed by hand-written fairness, backpressure, reset and saturation runs.
module tb_risc_v_alu_arbiter;
    import risc_v_alu_arbiter_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int IDW     = 2;
    localparam int CNT_W   = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_ready;
    instruction_t       req_instr [NUM_REQ];
    logic [31:0]        req_pc    [NUM_REQ];
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [31:0]        rsp_result;
    logic               rsp_zero;
    logic               rsp_illegal;
    logic [CNT_W-1:0]   illegal_count;

    risc_v_alu_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_instr     (req_instr),
        .req_pc        (req_pc),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_result    (rsp_result),
        .rsp_zero      (rsp_zero),
        .rsp_illegal   (rsp_illegal),
        .illegal_count (illegal_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        instruction_t instr;
        logic [31:0]  pc;
        logic [31:0]  exp_result;
        logic         exp_zero;
        logic         exp_illegal;
    } vec_t;

    vec_t vecs [17];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic instruction_t rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3);
        return {f7, rs2, rs1, f3, 5'd1, 7'h33};
    endfunction

    function automatic instruction_t utype(input logic [19:0] imm, input logic [6:0] opc);
        return {imm, 5'd1, opc};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_instr[i] = '0;
            req_pc[i]    = '0;
        end
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        req_valid = '0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{rtype(7'h00, 5'd7,  5'd5,  3'd0), 32'h0, 32'h0000_000C, 1'b0, 1'b0};
        vecs[1]  = '{rtype(7'h20, 5'd5,  5'd3,  3'd0), 32'h0, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[2]  = '{rtype(7'h20, 5'd9,  5'd9,  3'd0), 32'h0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[3]  = '{rtype(7'h00, 5'd10, 5'd12, 3'd7), 32'h0, 32'h0000_0008, 1'b0, 1'b0};
        vecs[4]  = '{rtype(7'h00, 5'd10, 5'd12, 3'd6), 32'h0, 32'h0000_000E, 1'b0, 1'b0};
        vecs[5]  = '{rtype(7'h00, 5'd10, 5'd12, 3'd4), 32'h0, 32'h0000_0006, 1'b0, 1'b0};
        vecs[6]  = '{rtype(7'h00, 5'd4,  5'd3,  3'd1), 32'h0, 32'h0000_0030, 1'b0, 1'b0};
        vecs[7]  = '{rtype(7'h00, 5'd3,  5'd24, 3'd5), 32'h0, 32'h0000_0003, 1'b0, 1'b0};
        vecs[8]  = '{rtype(7'h20, 5'd1,  5'd31, 3'd5), 32'h0, 32'h0000_000F, 1'b0, 1'b0};
        vecs[9]  = '{rtype(7'h00, 5'd5,  5'd3,  3'd2), 32'h0, 32'h0000_0001, 1'b0, 1'b0};
        vecs[10] = '{rtype(7'h00, 5'd3,  5'd5,  3'd2), 32'h0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[11] = '{rtype(7'h00, 5'd31, 5'd2,  3'd3), 32'h0, 32'h0000_0001, 1'b0, 1'b0};
        vecs[12] = '{utype(20'hDEADB, 7'h37), 32'h0,   32'hDEAD_B000, 1'b0, 1'b0};
        vecs[13] = '{utype(20'h00001, 7'h17), 32'h100, 32'h0000_1100, 1'b0, 1'b0};
        vecs[14] = '{utype(20'hDEADB, 7'h17), 32'hEEF, 32'hDEAD_BEEF, 1'b0, 1'b0};
        vecs[15] = '{32'h0000_0000, 32'h0,             32'hDEAD_BEEF, 1'b0, 1'b1};
        vecs[16] = '{rtype(7'h01, 5'd7,  5'd5,  3'd0), 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1};

        // Reset state
        reset     = 1'b1;
        rsp_ready = 1'b1;
        clear_reqs();
        tick();
        tick();
        chk("reset_rsp_valid",   rsp_valid,     0);
        chk("reset_rsp_id",      rsp_id,        0);
        chk("reset_rsp_result",  rsp_result,    0);
        chk("reset_rsp_zero",    rsp_zero,      0);
        chk("reset_rsp_illegal", rsp_illegal,   0);
        chk("reset_count",       illegal_count, 0);
        reset = 1'b0;
        #1;
        chk("idle_req_ready", req_ready, 0);

        // Back-to-back vectors through requester 2
        for (int i = 0; i < 17; i++) begin
            req_valid    = 4'b0100;
            req_instr[2] = vecs[i].instr;
            req_pc[2]    = vecs[i].pc;
            #1;
            chk($sformatf("vec%0d_req_ready", i), req_ready, 4'b0100);
            tick();
            chk($sformatf("vec%0d_rsp_valid", i), rsp_valid, 1);
            chk($sformatf("vec%0d_rsp_id", i), rsp_id, 2);
            chk($sformatf("vec%0d_result", i), rsp_result, vecs[i].exp_result);
            chk($sformatf("vec%0d_zero", i), rsp_zero, vecs[i].exp_zero);
            chk($sformatf("vec%0d_illegal", i), rsp_illegal, vecs[i].exp_illegal);
        end
        req_valid    = '0;
        req_instr[2] = '0;
        req_pc[2]    = '0;
        #1;
        chk("drain_req_ready", req_ready, 0);
        tick();
        chk("drain_rsp_valid", rsp_valid, 0);
        chk("drain_result_hold", rsp_result, 32'hDEAD_BEEF);
        chk("table_illegal_count", illegal_count, 2);

        // Pointer advanced past requester 2
        req_valid = 4'b1111;
        #1;
        chk("ptr3_req_ready", req_ready, 4'b1000);
        tick();
        chk("ptr3_rsp_id", rsp_id, 3);

        // Fairness with all requesters competing
        apply_reset();
        for (int i = 0; i < NUM_REQ; i++) req_instr[i] = rtype(7'h00, 5'd10, 5'(i), 3'd0);
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk($sformatf("fair%0d_req_ready", k), req_ready, 4'b0001 << (k % 4));
            tick();
            chk($sformatf("fair%0d_rsp_valid", k), rsp_valid, 1);
            chk($sformatf("fair%0d_rsp_id", k), rsp_id, k % 4);
            chk($sformatf("fair%0d_result", k), rsp_result, 10 + (k % 4));
        end
        req_valid = '0;
        tick();

        // Backpressure: held response, no grants, then drain plus refill
        apply_reset();
        req_instr[0] = rtype(7'h00, 5'd1, 5'd1, 3'd0);
        req_instr[1] = rtype(7'h00, 5'd3, 5'd4, 3'd0);
        req_valid    = 4'b0010;
        #1;
        chk("bp_first_ready", req_ready, 4'b0010);
        tick();
        chk("bp_first_id", rsp_id, 1);
        chk("bp_first_result", rsp_result, 7);
        rsp_ready = 1'b0;
        req_valid = 4'b0011;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp%0d_req_ready", k), req_ready, 0);
            tick();
            chk($sformatf("bp%0d_rsp_valid", k), rsp_valid, 1);
            chk($sformatf("bp%0d_rsp_id", k), rsp_id, 1);
            chk($sformatf("bp%0d_result", k), rsp_result, 7);
            chk($sformatf("bp%0d_illegal", k), rsp_illegal, 0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", req_ready, 4'b0001);
        tick();
        chk("bp_release_valid", rsp_valid, 1);
        chk("bp_release_id", rsp_id, 0);
        chk("bp_release_result", rsp_result, 2);
        req_valid = 4'b0010;
        #1;
        chk("bp_next_ready", req_ready, 4'b0010);
        tick();
        chk("bp_next_id", rsp_id, 1);
        req_valid = '0;
        tick();
        chk("bp_idle_valid", rsp_valid, 0);

        // Reset while a response is stalled
        req_instr[0] = '0;
        req_valid    = 4'b0001;
        rsp_ready    = 1'b0;
        #1;
        chk("rs_ready", req_ready, 4'b0001);
        tick();
        chk("rs_stall_valid", rsp_valid, 1);
        chk("rs_stall_illegal", rsp_illegal, 1);
        chk("rs_stall_count", illegal_count, 1);
        req_valid = '0;
        reset     = 1'b1;
        tick();
        reset = 1'b0;
        chk("rs_after_valid", rsp_valid, 0);
        chk("rs_after_count", illegal_count, 0);
        rsp_ready    = 1'b1;
        req_instr[3] = rtype(7'h00, 5'd0, 5'd3, 3'd0);
        req_valid    = 4'b1000;
        #1;
        chk("rs_req3_ready", req_ready, 4'b1000);
        tick();
        chk("rs_req3_id", rsp_id, 3);
        chk("rs_req3_result", rsp_result, 3);
        req_valid = 4'b1111;
        #1;
        chk("rs_all_ready", req_ready, 4'b0001);
        tick();
        chk("rs_all_id", rsp_id, 0);

        // Counter saturation
        apply_reset();
        req_instr[0] = '0;
        req_valid    = 4'b0001;
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_fffe", illegal_count, 16'hFFFE);
        tick();
        chk("sat_ffff", illegal_count, 16'hFFFF);
        repeat (3) @(posedge clk);
        #1;
        chk("sat_hold", illegal_count, 16'hFFFF);
        chk("sat_illegal", rsp_illegal, 1);
        req_valid = '0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
